// File: rtl/sram22_arb_pkg.sv
// Shared types and default geometry for the two-port sram22 arbiter.
package sram22_arb_pkg;

    localparam int SRAM22_DATA_WIDTH  = 64;
    localparam int SRAM22_ADDR_WIDTH  = 11;
    localparam int SRAM22_WMASK_WIDTH = 8;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    typedef struct packed {
        logic                          we;
        logic [SRAM22_WMASK_WIDTH-1:0] wmask;
        logic [SRAM22_ADDR_WIDTH-1:0]  addr;
        logic [SRAM22_DATA_WIDTH-1:0]  wdata;
    } sram_req_t;

    function automatic port_e other_port(input port_e p);
        return (p == PORT_A) ? PORT_B : PORT_A;
    endfunction

endpackage

// File: rtl/sram22_rsp_fifo.sv
// Per-port read-response FIFO: captures macro read data so response
// backpressure never stalls the shared macro.
module sram22_rsp_fifo
    import sram22_arb_pkg::*;
#(
    parameter int  DATA_WIDTH = SRAM22_DATA_WIDTH,
    parameter int  RSP_DEPTH  = 2,
    localparam int CNT_W      = $clog2(RSP_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  valid,
    output logic [CNT_W-1:0]      occ
);

    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [RSP_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // NOTE: storage is deliberately not reset; count and pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign pop_data = mem[rd_ptr];
    assign valid    = (count != '0);
    assign occ      = count;

endmodule

// File: rtl/sram22_rr_arbiter.sv
// Round-robin arbiter sharing one single-port sram22 macro between requesters A and B,
// with credit-checked per-port response FIFOs.
module sram22_rr_arbiter
    import sram22_arb_pkg::*;
#(
    parameter int DATA_WIDTH  = SRAM22_DATA_WIDTH,
    parameter int ADDR_WIDTH  = SRAM22_ADDR_WIDTH,
    parameter int WMASK_WIDTH = SRAM22_WMASK_WIDTH,
    parameter int RSP_DEPTH   = 2
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   a_req_valid,
    output logic                   a_req_ready,
    input  logic                   a_req_we,
    input  logic [WMASK_WIDTH-1:0] a_req_wmask,
    input  logic [ADDR_WIDTH-1:0]  a_req_addr,
    input  logic [DATA_WIDTH-1:0]  a_req_wdata,
    output logic                   a_rsp_valid,
    input  logic                   a_rsp_ready,
    output logic [DATA_WIDTH-1:0]  a_rsp_rdata,

    input  logic                   b_req_valid,
    output logic                   b_req_ready,
    input  logic                   b_req_we,
    input  logic [WMASK_WIDTH-1:0] b_req_wmask,
    input  logic [ADDR_WIDTH-1:0]  b_req_addr,
    input  logic [DATA_WIDTH-1:0]  b_req_wdata,
    output logic                   b_rsp_valid,
    input  logic                   b_rsp_ready,
    output logic [DATA_WIDTH-1:0]  b_rsp_rdata,

    output logic                   sram_we,
    output logic [WMASK_WIDTH-1:0] sram_wmask,
    output logic [ADDR_WIDTH-1:0]  sram_addr,
    output logic [DATA_WIDTH-1:0]  sram_din,
    input  logic [DATA_WIDTH-1:0]  sram_dout
);

    localparam int CNT_W = $clog2(RSP_DEPTH + 1);

    typedef struct packed {
        logic                   we;
        logic [WMASK_WIDTH-1:0] wmask;
        logic [ADDR_WIDTH-1:0]  addr;
        logic [DATA_WIDTH-1:0]  wdata;
    } req_t;

    req_t                   req_a, req_b, win_req;
    logic                   elig_a, elig_b;
    logic                   grant_a, grant_b, any_grant;
    port_e                  prio, win_port;
    logic                   infl_valid;
    port_e                  infl_port;
    logic                   infl_a, infl_b;
    logic                   pop_a, pop_b;
    logic [CNT_W-1:0]       occ_a, occ_b;
    logic [WMASK_WIDTH-1:0] last_wmask;
    logic [ADDR_WIDTH-1:0]  last_addr;
    logic [DATA_WIDTH-1:0]  last_din;

    assign req_a = '{a_req_we, a_req_wmask, a_req_addr, a_req_wdata};
    assign req_b = '{b_req_we, b_req_wmask, b_req_addr, b_req_wdata};

    assign infl_a = infl_valid && (infl_port == PORT_A);
    assign infl_b = infl_valid && (infl_port == PORT_B);
    assign pop_a  = a_rsp_valid & a_rsp_ready;
    assign pop_b  = b_rsp_valid & b_rsp_ready;

    // A read may issue only if its data is guaranteed a FIFO slot, counting this cycle's pop.
    function automatic logic has_credit(input logic [CNT_W-1:0] occ, input logic infl, input logic pop);
        return (int'(occ) + int'(infl) - int'(pop)) < RSP_DEPTH;
    endfunction

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        grant_a  = 1'b0;
        grant_b  = 1'b0;
        elig_a   = a_req_valid & (a_req_we | has_credit(occ_a, infl_a, pop_a));
        elig_b   = b_req_valid & (b_req_we | has_credit(occ_b, infl_b, pop_b));
        if (!rst) begin
            if (elig_a && elig_b) begin
                grant_a = (prio == PORT_A);
                grant_b = (prio == PORT_B);
            end else begin
                grant_a = elig_a;
                grant_b = elig_b;
            end
        end
        any_grant = grant_a | grant_b;
        win_port  = grant_b ? PORT_B : PORT_A;
        win_req   = grant_b ? req_b : req_a;
    end

    assign a_req_ready = grant_a;
    assign b_req_ready = grant_b;

    // Idle cycles keep the last granted address/data; the macro read they cause is never captured.
    assign sram_we    = any_grant & win_req.we;
    assign sram_wmask = any_grant ? win_req.wmask : last_wmask;
    assign sram_addr  = any_grant ? win_req.addr  : last_addr;
    assign sram_din   = any_grant ? win_req.wdata : last_din;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio       <= PORT_A;
            infl_valid <= 1'b0;
            infl_port  <= PORT_A;
            last_wmask <= '0;
            last_addr  <= '0;
            last_din   <= '0;
        end else begin
            infl_valid <= any_grant & ~win_req.we;
            infl_port  <= win_port;
            if (any_grant) begin
                prio       <= other_port(win_port);
                last_wmask <= win_req.wmask;
                last_addr  <= win_req.addr;
                last_din   <= win_req.wdata;
            end
        end
    end

    sram22_rsp_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .RSP_DEPTH  (RSP_DEPTH)
    ) u_fifo_a (
        .clk       (clk),
        .rst       (rst),
        .push      (infl_a),
        .push_data (sram_dout),
        .pop       (pop_a),
        .pop_data  (a_rsp_rdata),
        .valid     (a_rsp_valid),
        .occ       (occ_a)
    );

    sram22_rsp_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .RSP_DEPTH  (RSP_DEPTH)
    ) u_fifo_b (
        .clk       (clk),
        .rst       (rst),
        .push      (infl_b),
        .push_data (sram_dout),
        .pop       (pop_b),
        .pop_data  (b_rsp_rdata),
        .valid     (b_rsp_valid),
        .occ       (occ_b)
    );

endmodule

// File: tb/tb_sram22_rr_arbiter.sv
// Scoreboard bench for sram22_rr_arbiter: a reference model predicts grants, macro
// contents and response timing; a monitor compares returned read data in order.
`timescale 1ns/1ps
module tb_sram22_rr_arbiter;
    import sram22_arb_pkg::*;

    localparam int DW    = SRAM22_DATA_WIDTH;
    localparam int AW    = SRAM22_ADDR_WIDTH;
    localparam int MW    = SRAM22_WMASK_WIDTH;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_ready;
    logic [MW-1:0] a_req_wmask;
    logic [AW-1:0] a_req_addr;
    logic [DW-1:0] a_req_wdata, a_rsp_rdata;
    logic          b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready;
    logic [MW-1:0] b_req_wmask;
    logic [AW-1:0] b_req_addr;
    logic [DW-1:0] b_req_wdata, b_rsp_rdata;
    logic          sram_we;
    logic [MW-1:0] sram_wmask;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_din, sram_dout;

    always #5 clk = ~clk;

    sram22_rr_arbiter #(.RSP_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
        .a_req_wmask(a_req_wmask), .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata),
        .a_rsp_valid(a_rsp_valid), .a_rsp_ready(a_rsp_ready), .a_rsp_rdata(a_rsp_rdata),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
        .b_req_wmask(b_req_wmask), .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata),
        .b_rsp_valid(b_rsp_valid), .b_rsp_ready(b_rsp_ready), .b_rsp_rdata(b_rsp_rdata),
        .sram_we(sram_we), .sram_wmask(sram_wmask), .sram_addr(sram_addr),
        .sram_din(sram_din), .sram_dout(sram_dout)
    );

    // Behavioural sram22 macro: masked write and 1-cycle synchronous read.
    logic [DW-1:0] macro_mem [2**AW] = '{default: '0};
    always @(posedge clk) begin
        if (sram_we)
            for (int i = 0; i < MW; i++)
                if (sram_wmask[i]) macro_mem[sram_addr][8*i +: 8] <= sram_din[8*i +: 8];
        sram_dout <= macro_mem[sram_addr];
    end

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model state: memory as seen in grant order, per-port expectations.
    logic [DW-1:0] model_mem [2**AW] = '{default: '0};
    int            avail_q [2][$];
    logic [DW-1:0] exp_q   [2][$];
    int            outstanding [2];
    int            prio;
    int            cyc;
    logic [AW-1:0] exp_addr;
    logic [MW-1:0] exp_mask;
    logic [DW-1:0] exp_din;
    logic          m_v [2], m_we [2], m_rr [2], m_pop [2], m_elig [2], m_ev [2];
    logic [AW-1:0] m_ad [2];
    logic [MW-1:0] m_mk [2];
    logic [DW-1:0] m_wd [2];

    function automatic logic rsp_valid_of(input int p);
        return (p == 0) ? a_rsp_valid : b_rsp_valid;
    endfunction
    function automatic logic [DW-1:0] rdata_of(input int p);
        return (p == 0) ? a_rsp_rdata : b_rsp_rdata;
    endfunction
    function automatic logic req_ready_of(input int p);
        return (p == 0) ? a_req_ready : b_req_ready;
    endfunction

    initial begin : model
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                check("rst_a_req_ready", a_req_ready, 0);
                check("rst_b_req_ready", b_req_ready, 0);
                check("rst_a_rsp_valid", a_rsp_valid, 0);
                check("rst_b_rsp_valid", b_rsp_valid, 0);
                check("rst_sram_we", sram_we, 0);
                check("rst_sram_addr", sram_addr, 0);
                for (int p = 0; p < 2; p++) begin
                    avail_q[p].delete();
                    exp_q[p].delete();
                    outstanding[p] = 0;
                end
                prio = 0;
                exp_addr = '0;
                exp_mask = '0;
                exp_din  = '0;
            end else begin
                int win;
                m_v[0]  = a_req_valid; m_we[0] = a_req_we; m_ad[0] = a_req_addr;
                m_mk[0] = a_req_wmask; m_wd[0] = a_req_wdata; m_rr[0] = a_rsp_ready;
                m_v[1]  = b_req_valid; m_we[1] = b_req_we; m_ad[1] = b_req_addr;
                m_mk[1] = b_req_wmask; m_wd[1] = b_req_wdata; m_rr[1] = b_rsp_ready;
                for (int p = 0; p < 2; p++) begin
                    m_ev[p]   = (avail_q[p].size() > 0) && (avail_q[p][0] <= cyc);
                    m_pop[p]  = m_ev[p] && m_rr[p];
                    m_elig[p] = m_v[p] && (m_we[p] || (outstanding[p] - int'(m_pop[p]) < DEPTH));
                    check((p == 0) ? "a_rsp_valid" : "b_rsp_valid", rsp_valid_of(p), m_ev[p]);
                end
                win = -1;
                if (m_elig[0] && m_elig[1]) win = prio;
                else if (m_elig[0])         win = 0;
                else if (m_elig[1])         win = 1;
                check("a_req_ready", a_req_ready, win == 0);
                check("b_req_ready", b_req_ready, win == 1);
                if (win >= 0) begin
                    check("sram_we", sram_we, m_we[win]);
                    exp_addr = m_ad[win];
                    exp_mask = m_mk[win];
                    exp_din  = m_wd[win];
                    if (m_we[win]) begin
                        for (int i = 0; i < MW; i++)
                            if (m_mk[win][i]) model_mem[m_ad[win]][8*i +: 8] = m_wd[win][8*i +: 8];
                    end else begin
                        avail_q[win].push_back(cyc + 2);
                        exp_q[win].push_back(model_mem[m_ad[win]]);
                        outstanding[win]++;
                    end
                    prio = 1 - win;
                end else begin
                    check("idle_sram_we", sram_we, 0);
                end
                check("sram_addr", sram_addr, exp_addr);
                check("sram_wmask", sram_wmask, exp_mask);
                check("sram_din", sram_din, exp_din);
                for (int p = 0; p < 2; p++) begin
                    if (m_pop[p]) begin
                        void'(avail_q[p].pop_front());
                        outstanding[p]--;
                    end
                    check((p == 0) ? "a_no_overflow" : "b_no_overflow", outstanding[p] <= DEPTH, 1);
                end
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                for (int p = 0; p < 2; p++) begin
                    if (rsp_valid_of(p) && ((p == 0) ? a_rsp_ready : b_rsp_ready)) begin
                        check((p == 0) ? "a_rsp_expected" : "b_rsp_expected", exp_q[p].size() > 0, 1);
                        if (exp_q[p].size() > 0)
                            check((p == 0) ? "a_rsp_rdata" : "b_rsp_rdata", rdata_of(p), exp_q[p].pop_front());
                    end
                end
            end
        end
    end

    function automatic sram_req_t mk_req(input logic we, input logic [MW-1:0] m,
                                         input logic [AW-1:0] ad, input logic [DW-1:0] d);
        sram_req_t r;
        r.we = we; r.wmask = m; r.addr = ad; r.wdata = d;
        return r;
    endfunction

    task automatic set_req(input int p, input logic v, input sram_req_t r);
        if (p == 0) begin
            a_req_valid = v; a_req_we = r.we; a_req_wmask = r.wmask;
            a_req_addr = r.addr; a_req_wdata = r.wdata;
        end else begin
            b_req_valid = v; b_req_we = r.we; b_req_wmask = r.wmask;
            b_req_addr = r.addr; b_req_wdata = r.wdata;
        end
    endtask

    // Holds a request until accepted, then leaves the port idle one cycle into the next.
    task automatic send(input int p, input sram_req_t r);
        int waited = 0;
        set_req(p, 1'b1, r);
        forever begin
            @(negedge clk);
            if (req_ready_of(p)) break;
            waited++;
            if (waited >= 300) begin
                check((p == 0) ? "a_req_accept_timeout" : "b_req_accept_timeout", req_ready_of(p), 1);
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        set_req(p, 1'b0, mk_req(1'b0, '0, '0, '0));
    endtask

    task automatic read_expect(input int p, input logic [AW-1:0] ad, input logic [DW-1:0] exp, input string name);
        send(p, mk_req(1'b0, '0, ad, '0));
        @(negedge clk);
        check({name, "_valid_at_1"}, rsp_valid_of(p), 0);
        @(negedge clk);
        check({name, "_valid_at_2"}, rsp_valid_of(p), 1);
        check({name, "_rdata"}, rdata_of(p), exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic rand_port(input int p);
        repeat (250) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            send(p, mk_req(1'($urandom_range(0, 1)), 8'($urandom),
                           11'h100 + 11'($urandom_range(0, 7)), {$urandom, $urandom}));
        end
    endtask

    bit rnd_done;

    initial begin : stimulus
        rst = 1'b1;
        set_req(0, 1'b0, mk_req(1'b0, '0, '0, '0));
        set_req(1, 1'b0, mk_req(1'b0, '0, '0, '0));
        a_rsp_ready = 1'b1;
        b_rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Write then read back on port A.
        send(0, mk_req(1'b1, 8'hFF, 11'h005, 64'h1122334455667788));
        read_expect(0, 11'h005, 64'h1122334455667788, "a_wr_rd_005");
        idle(3);

        // Contention: grants alternate A,B starting with A after reset.
        do_reset();
        fork
            begin for (int i = 0; i < 8; i++) send(0, mk_req(1'b0, '0, 11'h010, '0)); end
            begin for (int i = 0; i < 8; i++) send(1, mk_req(1'b0, '0, 11'h020, '0)); end
            begin
                for (int i = 0; i < 6; i++) begin
                    @(negedge clk);
                    check("alternate_sram_addr", sram_addr, (i % 2 == 0) ? 11'h010 : 11'h020);
                end
            end
        join
        idle(4);

        // Byte-masked write at the top address.
        send(0, mk_req(1'b1, 8'hFF, 11'h7FF, 64'hFFFFFFFFFFFFFFFF));
        send(0, mk_req(1'b1, 8'h0F, 11'h7FF, 64'h0));
        read_expect(0, 11'h7FF, 64'hFFFFFFFF00000000, "a_masked_7ff");
        idle(3);

        // Port B backpressured: only DEPTH reads accepted, A keeps going.
        b_rsp_ready = 1'b0;
        fork
            begin for (int i = 0; i < 4; i++) send(1, mk_req(1'b0, '0, 11'h020 + 11'(i), '0)); end
            begin for (int i = 0; i < 6; i++) send(0, mk_req(1'b0, '0, 11'h010, '0)); end
            begin
                repeat (14) @(posedge clk);
                @(negedge clk);
                check("b_stalled_valid", b_req_valid, 1);
                check("b_stalled_no_credit", b_req_ready, 0);
                @(posedge clk);
                #1 b_rsp_ready = 1'b1;
            end
        join
        idle(5);

        // Reset while both ports have reads in flight.
        fork
            begin for (int i = 0; i < 6; i++) send(0, mk_req(1'b0, '0, 11'h040 + 11'(i), '0)); end
            begin for (int i = 0; i < 6; i++) send(1, mk_req(1'b0, '0, 11'h050 + 11'(i), '0)); end
            begin
                repeat (3) @(posedge clk);
                #1 rst = 1'b1;
                #1;
                check("rst_drop_a_rsp_valid", a_rsp_valid, 0);
                check("rst_drop_b_rsp_valid", b_rsp_valid, 0);
                @(posedge clk);
                #1 rst = 1'b0;
                @(negedge clk);
                check("post_rst_first_grant_a", a_req_ready, 1);
                check("post_rst_first_grant_b", b_req_ready, 0);
            end
        join
        idle(5);

        // A writes, B reads the same address on the very next grant.
        do_reset();
        fork
            send(0, mk_req(1'b1, 8'hFF, 11'h3A0, 64'hCAFEBABE0BADF00D));
            read_expect(1, 11'h3A0, 64'hCAFEBABE0BADF00D, "b_raw_3a0");
        join
        idle(3);

        // Randomized traffic with random response backpressure.
        rnd_done = 1'b0;
        fork
            begin
                fork
                    rand_port(0);
                    rand_port(1);
                join
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    a_rsp_ready = ($urandom_range(0, 3) != 0);
                    b_rsp_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        a_rsp_ready = 1'b1;
        b_rsp_ready = 1'b1;
        idle(10);
        check("a_drained", exp_q[0].size(), 0);
        check("b_drained", exp_q[1].size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not complete, %0d checks so far", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
